// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-ticked Pong controller: serve/play/over FSM, ball physics, paddles and score.
// Optional PONG_AUTO_PADDLE_EN: both paddles track the ball and the buttons are ignored.
module pong_game_ctrl #(
  parameter int VIDEO_W      = 640,
  parameter int VIDEO_H      = 480,
  parameter int TOP          = 60,
  parameter int BOTTOM       = 468,
  parameter int BALL         = 12,
  parameter int PAD_H        = 60,
  parameter int PAD_W        = 10,
  parameter int PAD1_X       = 50,
  parameter int PAD2_X       = 600,
  parameter int SPEED        = 2,
  parameter int PAD_SPEED    = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        iVS,
  input  logic        iSERVE,
  input  logic        iP1_UP,
  input  logic        iP1_DN,
  input  logic        iP2_UP,
  input  logic        iP2_DN,
  output logic [10:0] oBALL_X,
  output logic [9:0]  oBALL_Y,
  output logic [9:0]  oPAD1_Y,
  output logic [9:0]  oPAD2_Y,
  output logic [3:0]  oSCORE1,
  output logic [3:0]  oSCORE2,
  output logic [1:0]  oSTATE,
  output logic [1:0]  oWIN
);
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} stateT;
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [10:0] CX = 11'((VIDEO_W - BALL) / 2);
  localparam logic [9:0] CY = 10'((TOP + BOTTOM - BALL) / 2);
  localparam logic [9:0] PR = 10'((VIDEO_H - PAD_H) / 2);
  localparam logic [3:0] WS = 4'(WIN_SCORE);
  localparam logic signed [12:0] SP = 13'(SPEED), PS = 13'(PAD_SPEED), BS = 13'(BALL), PH = 13'(PAD_H);
  localparam logic signed [12:0] YT = 13'(TOP), YB = 13'(BOTTOM), YBB = 13'(BOTTOM - BALL), YPM = 13'(BOTTOM - PAD_H);
  localparam logic signed [12:0] P1L = 13'(PAD1_X), P1R = 13'(PAD1_X + PAD_W);
  localparam logic signed [12:0] P2L = 13'(PAD2_X), P2R = 13'(PAD2_X + PAD_W), P2B = 13'(PAD2_X - BALL);
  localparam logic signed [12:0] XL = 13'(SPEED), XR = 13'(VIDEO_W - SPEED);

  stateT state;
  logic vsPrev, frameTick;
  logic [CW-1:0] serveCnt;
  logic signed [1:0] dx, dy, ndx, ndy;
  logic signed [12:0] xS, yS, p1, p2, nx0, ny0, nx, ny, d1, d2;
  logic topHit, botHit, hit1, hit2, miss1, miss2;
  logic [3:0] s1n, s2n;

  // Step is limited to PAD_SPEED, then the top edge is kept inside the walls.
  function automatic logic [9:0] padMove(input logic signed [12:0] p, input logic signed [12:0] d);
    logic signed [12:0] q;
    q = p + (d > PS ? PS : d < -PS ? -PS : d);
    return 10'(q < YT ? YT : q > YPM ? YPM : q);
  endfunction

  assign xS = 13'(oBALL_X);
  assign yS = 13'(oBALL_Y);
  assign p1 = 13'(oPAD1_Y);
  assign p2 = 13'(oPAD2_Y);
  assign s1n = oSCORE1 + 4'd1;
  assign s2n = oSCORE2 + 4'd1;
  assign oSTATE = state;

`ifdef PONG_AUTO_PADDLE_EN
  localparam logic signed [12:0] TRK = 13'(BALL / 2 - PAD_H / 2);
  logic unusedBtn;
  assign unusedBtn = ^{iP1_UP, iP1_DN, iP2_UP, iP2_DN};
  assign d1 = yS + TRK - p1;
  assign d2 = yS + TRK - p2;
`else
  assign d1 = iP1_UP == iP1_DN ? '0 : iP1_UP ? -PS : PS;
  assign d2 = iP2_UP == iP2_DN ? '0 : iP2_UP ? -PS : PS;
`endif

  // Walls resolve first so paddle overlap is judged on the clamped row.
  always_comb begin
    ny0 = yS + (dy[1] ? -SP : SP);
    nx0 = xS + (dx[1] ? -SP : SP);
    topHit = ny0 <= YT;
    botHit = !topHit && ny0 + BS >= YB;
    ny = topHit ? YT : botHit ? YBB : ny0;
    ndy = topHit ? 2'sd1 : botHit ? -2'sd1 : dy;
    hit1 = dx[1] && nx0 <= P1R && nx0 + BS > P1L && ny < p1 + PH && ny + BS > p1;
    hit2 = !dx[1] && nx0 + BS >= P2L && nx0 < P2R && ny < p2 + PH && ny + BS > p2;
    nx = hit1 ? P1R : hit2 ? P2B : nx0;
    ndx = hit1 ? 2'sd1 : hit2 ? -2'sd1 : dx;
    miss1 = nx <= XL;
    miss2 = nx + BS >= XR;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vsPrev <= 1'b1;
      frameTick <= 1'b0;
      state <= IDLE;
      serveCnt <= '0;
      dx <= 2'sd1;
      dy <= 2'sd1;
      oBALL_X <= CX;
      oBALL_Y <= CY;
      oPAD1_Y <= PR;
      oPAD2_Y <= PR;
      oSCORE1 <= '0;
      oSCORE2 <= '0;
      oWIN <= '0;
    end else begin
      vsPrev <= iVS;
      frameTick <= vsPrev & ~iVS;
      if (frameTick) begin
        oPAD1_Y <= padMove(p1, d1);
        oPAD2_Y <= padMove(p2, d2);
        case (state)
          IDLE: if (iSERVE) state <= SERVE;
          SERVE: begin
            oBALL_X <= CX;
            oBALL_Y <= CY;
            serveCnt <= serveCnt == CW'(SERVE_FRAMES - 1) ? '0 : serveCnt + CW'(1);
            if (serveCnt == CW'(SERVE_FRAMES - 1)) state <= PLAY;
          end
          PLAY: begin
            dx <= ndx;
            dy <= ndy;
            oBALL_X <= 11'(nx);
            oBALL_Y <= 10'(ny);
            if (miss1 || miss2) begin
              oBALL_X <= CX;
              oBALL_Y <= CY;
              dx <= miss1 ? -2'sd1 : 2'sd1;
              if (miss1) oSCORE2 <= s2n;
              else oSCORE1 <= s1n;
              if (miss1 ? s2n == WS : s1n == WS) begin
                state <= OVER;
                oWIN <= miss1 ? 2'b10 : 2'b01;
              end else state <= SERVE;
            end
          end
          OVER: if (iSERVE) begin
            oSCORE1 <= '0;
            oSCORE2 <= '0;
            oWIN <= '0;
            state <= SERVE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: frame-level reference model with a scoreboard queue, a paddle vector
// table and hand-written serve, miss, win and reset sequences.
module tb_pong_game_ctrl;
  logic clk = 1'b0, rstN = 1'b0, vs = 1'b1, serve = 1'b0;
  logic p1u = 1'b0, p1d = 1'b0, p2u = 1'b0, p2d = 1'b0;
  logic [10:0] ballX;
  logic [9:0] ballY, pad1, pad2;
  logic [3:0] score1, score2;
  logic [1:0] state, win;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .iVGA_CLK(clk), .iRST_n(rstN), .iVS(vs), .iSERVE(serve),
    .iP1_UP(p1u), .iP1_DN(p1d), .iP2_UP(p2u), .iP2_DN(p2d),
    .oBALL_X(ballX), .oBALL_Y(ballY), .oPAD1_Y(pad1), .oPAD2_Y(pad2),
    .oSCORE1(score1), .oSCORE2(score2), .oSTATE(state), .oWIN(win)
  );

  typedef struct packed {
    logic [1:0] st; logic [10:0] bx; logic [9:0] by, p1, p2; logic [3:0] s1, s2; logic [1:0] w;
  } snapT;
  typedef struct {logic u1, d1, u2, d2, sv; int n, e1, e2, est;} vecT;

  snapT expQ[$];
  vecT tbl[10];
  int tests = 0, fails = 0, frameNo = 0;
  int mSt, mBx, mBy, mDx, mDy, mP1, mP2, mS1, mS2, mWin, mCnt;

  function automatic int btn(int p, logic u, logic d);
    int q;
    q = p + ((u && !d) ? -4 : (d && !u) ? 4 : 0);
    return q < 60 ? 60 : q > 408 ? 408 : q;
  endfunction

  task automatic modelReset();
    mSt = 0; mBx = 314; mBy = 258; mDx = 1; mDy = 1; mP1 = 210; mP2 = 210;
    mS1 = 0; mS2 = 0; mWin = 0; mCnt = 0;
  endtask

  task automatic modelFrame();
    int nx, ny, n1, n2;
    n1 = btn(mP1, p1u, p1d);
    n2 = btn(mP2, p2u, p2d);
    if (mSt == 0) begin
      if (serve) mSt = 1;
    end else if (mSt == 1) begin
      mCnt++;
      if (mCnt == 60) begin mCnt = 0; mSt = 2; end
    end else if (mSt == 3) begin
      if (serve) begin mS1 = 0; mS2 = 0; mWin = 0; mSt = 1; end
    end else begin
      ny = mBy + 2 * mDy;
      nx = mBx + 2 * mDx;
      if (ny <= 60) begin ny = 60; mDy = 1; end
      else if (ny + 12 >= 468) begin ny = 456; mDy = -1; end
      if (mDx < 0 && nx <= 60 && nx + 12 > 50 && ny < mP1 + 60 && ny + 12 > mP1) begin nx = 60; mDx = 1; end
      else if (mDx > 0 && nx + 12 >= 600 && nx < 610 && ny < mP2 + 60 && ny + 12 > mP2) begin nx = 588; mDx = -1; end
      mBx = nx; mBy = ny;
      if (nx <= 2 || nx + 12 >= 638) begin
        if (nx <= 2) begin mS2++; mDx = -1; end
        else begin mS1++; mDx = 1; end
        mBx = 314; mBy = 258;
        if (mS1 == 9) begin mSt = 3; mWin = 1; end
        else if (mS2 == 9) begin mSt = 3; mWin = 2; end
        else mSt = 1;
      end
    end
    mP1 = n1; mP2 = n2;
  endtask

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic frame();
    snapT e, a;
    modelFrame();
    expQ.push_back({2'(mSt), 11'(mBx), 10'(mBy), 10'(mP1), 10'(mP2), 4'(mS1), 4'(mS2), 2'(mWin)});
    @(negedge clk) vs = 1'b0;
    repeat (3) @(negedge clk);
    vs = 1'b1;
    repeat (3) @(negedge clk);
    e = expQ.pop_front();
    a = {state, ballX, ballY, pad1, pad2, score1, score2, win};
    frameNo++;
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL frame%0d: got st=%0d ball=(%0d,%0d) pad=(%0d,%0d) score=%0d-%0d win=%0d, expected st=%0d ball=(%0d,%0d) pad=(%0d,%0d) score=%0d-%0d win=%0d",
               frameNo, a.st, a.bx, a.by, a.p1, a.p2, a.s1, a.s2, a.w, e.st, e.bx, e.by, e.p1, e.p2, e.s1, e.s2, e.w);
    end
  endtask

  task automatic doReset();
    {p1u, p1d, p2u, p2d, serve} = '0;
    vs = 1'b1;
    @(negedge clk) rstN = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 210, 210, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 50, 60, 210, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5, 60, 210, 0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 64, 210, 0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 60, 64, 408, 0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3, 64, 408, 0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 100, 408, 60, 0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 408, 64, 0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 408, 64, 1};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10, 368, 64, 1};

    doReset();
    check("rst state", state, 0);
    check("rst ballX", ballX, 314);
    check("rst ballY", ballY, 258);
    check("rst pad1", pad1, 210);
    check("rst pad2", pad2, 210);
    check("rst scores", {score1, score2}, 0);
    check("rst win", win, 0);

    for (int i = 0; i < 10; i++) begin
      {p1u, p1d, p2u, p2d, serve} = {tbl[i].u1, tbl[i].d1, tbl[i].u2, tbl[i].d2, tbl[i].sv};
      repeat (tbl[i].n) frame();
      check($sformatf("vec%0d pad1", i), pad1, tbl[i].e1);
      check($sformatf("vec%0d pad2", i), pad2, tbl[i].e2);
      check($sformatf("vec%0d state", i), state, tbl[i].est);
    end

    // Asynchronous reset in the middle of a serve countdown, away from any clock edge.
    {p1u, p1d, p2u, p2d, serve} = '0;
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    check("async rst state", state, 0);
    check("async rst pad1", pad1, 210);
    modelReset();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    repeat (2) frame();
    check("post rst idle", state, 0);

    serve = 1'b1;
    frame();
    serve = 1'b0;
    repeat (59) frame();
    check("serve 59 ticks", state, 1);
    frame();
    check("serve 60 ticks", state, 2);
    frame();
    check("first step X", ballX, 316);
    check("first step Y", ballY, 260);

    // Player 2 returns the first serve; player 1's paddle parked low misses it.
    doReset();
    p1d = 1'b1; p2d = 1'b1; serve = 1'b1;
    frame();
    serve = 1'b0;
    repeat (39) frame();
    p2d = 1'b0;
    check("pad2 parked", pad2, 370);
    for (int f = 0; f < 800 && score2 == 0; f++) frame();
    check("miss score2", score2, 1);
    check("miss score1", score1, 0);
    check("miss state", state, 1);
    check("miss ballX", ballX, 314);
    check("miss ballY", ballY, 258);
    check("miss pad1", pad1, 408);
    repeat (61) frame();
    check("serve toward p1", ballX, 312);

    // Idle paddles at 210 never meet the ball, so player 1 wins 9-0.
    doReset();
    serve = 1'b1;
    frame();
    serve = 1'b0;
    for (int f = 0; f < 2500 && score1 != 8; f++) frame();
    check("eight score1", score1, 8);
    check("eight score2", score2, 0);
    check("eight state", state, 1);
    for (int f = 0; f < 400 && state != 3; f++) frame();
    check("win state", state, 3);
    check("win score1", score1, 9);
    check("win bits", win, 1);
    repeat (3) frame();
    check("over frozen X", ballX, 314);
    check("over score held", score1, 9);
    serve = 1'b1;
    frame();
    serve = 1'b0;
    check("restart state", state, 1);
    check("restart scores", {score1, score2}, 0);
    check("restart win", win, 0);
    repeat (5) frame();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
